// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multi-cycle RISC core.
// Holds the opcode constants, IR field bit positions, the NOP encoding and the
// fetch FSM state encoding used by the fetch unit and control unit.
package isa_pkg;

  // Opcodes below OP_RTYPE_LIMIT are register-register (R-type) operations.
  localparam logic [4:0] OP_RTYPE_LIMIT = 5'd7;
  localparam logic [4:0] OP_BEQ         = 5'b00111;
  localparam logic [4:0] OP_BNE         = 5'b01000;
  localparam logic [4:0] OP_LOAD        = 5'b01001;
  localparam logic [4:0] OP_STORE       = 5'b01010;
  localparam logic [4:0] OP_JUMP        = 5'b01011;

  // IR field positions. rs2 and imm overlap on IR[16:12]/IR[15:0]; which one
  // is meaningful depends on the opcode, decoded downstream.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 17;
  localparam int RS2_MSB = 16;
  localparam int RS2_LSB = 12;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,  // no valid IR
    FETCH_REQ  = 2'b01,  // read outstanding, waiting for ack
    FETCH_HOLD = 2'b10   // IR holds a completed fetch
  } fetch_state_t;

  function automatic logic is_rtype(input logic [4:0] op);
    return op < OP_RTYPE_LIMIT;
  endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select and adder for the instruction fetch unit (purely combinational).
// Ports: i_pc current PC; i_jump/i_branch/i_branch_cond select the update;
//        i_jump_tgt absolute jump target; i_imm raw 16-bit branch offset;
//        o_next_pc value loaded into the PC on a PC_enable edge.
module ifu_next_pc #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_jump,
  input  logic              i_branch,
  input  logic              i_branch_cond,
  input  logic [ADDR_W-1:0] i_jump_tgt,
  input  logic [15:0]       i_imm,
  output logic [ADDR_W-1:0] o_next_pc
);

  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_offset;

  // All arithmetic wraps naturally at ADDR_W bits.
  assign w_seq_pc = i_pc + ADDR_W'(1);
  // Signed size cast sign-extends the branch offset to the PC width.
  assign w_offset = ADDR_W'($signed(i_imm));

  // Jump outranks a taken branch, which outranks sequential flow.
  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_jump) begin
      o_next_pc = i_jump_tgt;
    end else if (i_branch && i_branch_cond) begin
      o_next_pc = w_seq_pc + w_offset;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues handshaked reads to instruction
// memory and exposes the decoded IR fields to the control unit and datapath.
// Ports: clk/reset (async, active-high); IR_enable fetch request; PC_enable PC
//        update strobe with branch/jump/branch_cond qualifiers; imem_req/imem_addr/
//        imem_rdata/imem_ack memory handshake; opcode/rd/rs1/rs2/imm IR fields;
//        pc; instr_valid; fetch_busy; fetch_err.
// Optional: define IFU_ACK_TIMEOUT_EN to compile in the ack watchdog, which aborts
//           a fetch after TIMEOUT ack-less REQ cycles, loads a NOP and sets fetch_err.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IR_enable,
  input  logic              PC_enable,
  input  logic              branch,
  input  logic              jump,
  input  logic              branch_cond,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [4:0]        opcode,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [31:0]       r_ir;
  logic [31:0]       w_ir_nxt;
  logic              r_instr_valid;
  logic              w_valid_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic              w_capture;
  logic              w_timeout;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_instr_valid;
    w_capture   = 1'b0;
    case (r_state)
      FETCH_IDLE, FETCH_HOLD: begin
        if (IR_enable) begin
          w_state_nxt = FETCH_REQ;
          w_capture   = 1'b1;
          w_valid_nxt = 1'b0;
        end
      end
      FETCH_REQ: begin
        // A new IR_enable here is ignored; the outstanding read must finish.
        if (imem_ack) begin
          w_state_nxt = FETCH_HOLD;
          w_ir_nxt    = imem_rdata;
          w_valid_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = FETCH_HOLD;
          w_ir_nxt    = NOP_INSTR;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir          <= NOP_INSTR;
      r_instr_valid <= 1'b0;
      r_req_addr    <= RESET_PC;
    end else begin
      r_ir          <= w_ir_nxt;
      r_instr_valid <= w_valid_nxt;
      // Captures the pre-update PC even when PC_enable fires in the same cycle.
      if (w_capture) begin
        r_req_addr <= r_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  ifu_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc         (r_pc),
    .i_jump       (jump),
    .i_branch     (branch),
    .i_branch_cond(branch_cond),
    .i_jump_tgt   (r_ir[ADDR_W-1:0]),
    .i_imm        (r_ir[IMM_MSB:IMM_LSB]),
    .o_next_pc    (w_pc_nxt)
  );

  // PC updates are honoured in every fetch state; imem_addr is decoupled via
  // r_req_addr so a mid-request update does not disturb the outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (PC_enable) begin
      r_pc <= w_pc_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Ack watchdog
  // ---------------------------------------------------------------------------
`ifdef IFU_ACK_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_fetch_err;

  // Counter holds the number of ack-less REQ cycles already elapsed, so the
  // abort fires in the TIMEOUT-th REQ cycle. A same-cycle ack takes priority.
  assign w_timeout = (r_state == FETCH_REQ) && !imem_ack &&
                     (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wd_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wd_cnt <= '0;
      end else if ((r_state == FETCH_REQ) && !imem_ack) begin
        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  // Without the watchdog REQ waits for ack indefinitely.
  localparam int unused_timeout = TIMEOUT;

  assign w_timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // imem_req comes straight from the state register, so reset drops it at once.
  assign imem_req    = (r_state == FETCH_REQ);
  assign fetch_busy  = (r_state == FETCH_REQ);
  assign imem_addr   = r_req_addr;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_ir[OPC_MSB:OPC_LSB];
  assign rd          = r_ir[RD_MSB:RD_LSB];
  assign rs1         = r_ir[RS1_MSB:RS1_LSB];
  assign rs2         = r_ir[RS2_MSB:RS2_LSB];
  assign imm         = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IR_enable = 1'b0;
  logic        PC_enable = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        branch_cond = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        instr_valid, fetch_busy, fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .ADDR_W(16), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .IR_enable(IR_enable), .PC_enable(PC_enable),
    .branch(branch), .jump(jump), .branch_cond(branch_cond),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .pc(pc), .instr_valid(instr_valid), .fetch_busy(fetch_busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rdv,
                                     input logic [4:0] rs1v, input logic [15:0] immv);
    return {op, rdv, rs1v, 1'b0, immv};
  endfunction

  // Full fetch: request, dly ack-less REQ cycles, then ack with word w.
  task automatic fetch(input logic [31:0] w, input int dly);
    IR_enable = 1'b1;
    tick();
    IR_enable = 1'b0;
    repeat (dly) tick();
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic pc_step(input logic j, input logic b, input logic c);
    PC_enable = 1'b1; jump = j; branch = b; branch_cond = c;
    tick();
    PC_enable = 1'b0; jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
  endtask

  task automatic set_pc(input logic [15:0] v);
    fetch(mk(5'b01011, 5'd0, 5'd0, v), 0);
    pc_step(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [15:0] start_pc;
    logic [31:0] word;
    logic        j, b, c;
    logic [15:0] exp_pc;
  } vec_t;

  // Reference model state
  int          m_pc;
  logic [31:0] m_ir;
  bit          m_valid, m_busy, m_err;
  logic [15:0] m_addr;
  int          m_wd;

  task automatic model_step();
    int npc;
    npc = m_pc;
    if (PC_enable) begin
      if (jump)                      npc = int'(m_ir & 32'h0000_FFFF);
      else if (branch && branch_cond) npc = (m_pc + 1 + int'($signed(m_ir[15:0]))) & 32'hFFFF;
      else                           npc = (m_pc + 1) & 32'hFFFF;
    end
    if (!m_busy) begin
      if (IR_enable) begin
        m_busy = 1; m_addr = m_pc[15:0]; m_valid = 0; m_wd = 0;
      end
    end else if (imem_ack) begin
      m_ir = imem_rdata; m_valid = 1; m_busy = 0;
    end else begin
      m_wd++;
`ifdef IFU_ACK_TIMEOUT_EN
      if (m_wd == TIMEOUT) begin
        m_ir = 32'h0; m_valid = 1; m_busy = 0; m_err = 1;
      end
`endif
    end
    m_pc = npc;
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] w;
    int          cnt;
    bit          addr_ok;

    vecs[0] = '{16'h0010, mk(5'b00111, 5'd1, 5'd2, 16'hFFFC), 1'b0, 1'b1, 1'b1, 16'h000D};
    vecs[1] = '{16'h0010, mk(5'b00111, 5'd1, 5'd2, 16'hFFFC), 1'b0, 1'b1, 1'b0, 16'h0011};
    vecs[2] = '{16'h0040, mk(5'b01011, 5'd0, 5'd0, 16'h0200), 1'b1, 1'b1, 1'b1, 16'h0200};
    vecs[3] = '{16'hFFFF, mk(5'b00000, 5'd3, 5'd4, 16'h1234), 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{16'h0100, mk(5'b01000, 5'd0, 5'd5, 16'h0005), 1'b0, 1'b1, 1'b1, 16'h0106};
    vecs[5] = '{16'hFFFE, mk(5'b00111, 5'd0, 5'd0, 16'h0003), 1'b0, 1'b1, 1'b1, 16'h0002};
    vecs[6] = '{16'h8000, mk(5'b00111, 5'd0, 5'd0, 16'h8000), 1'b0, 1'b1, 1'b1, 16'h0001};
    vecs[7] = '{16'h1234, mk(5'b01011, 5'd0, 5'd0, 16'hFFFF), 1'b1, 1'b0, 1'b0, 16'hFFFF};

    do_reset();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_fields", {opcode, rd, rs1, rs2, imm}, 32'h0);
    chk("rst_req_busy_valid_err", {imem_req, fetch_busy, instr_valid, fetch_err}, 32'h0);

    // Fetch with ack in the first REQ cycle
    IR_enable = 1'b1;
    tick();
    chk("a_req_busy", {imem_req, fetch_busy}, 32'h3);
    chk("a_addr", imem_addr, 32'h0);
    chk("a_valid_n1", instr_valid, 32'h0);
    IR_enable  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h4880_0005;
    tick();
    imem_ack = 1'b0;
    chk("a_valid_n2", instr_valid, 32'h1);
    chk("a_req_drop", imem_req, 32'h0);
    chk("a_opcode", opcode, 32'h09);
    chk("a_rd", rd, 32'h2);
    chk("a_imm", imm, 32'h5);

    // Ack outside REQ is ignored
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    chk("hold_ack_ignored", {opcode, imm}, {11'h0, 5'h09, 16'h0005});

    // Ack delayed 3 cycles, PC_enable and a stray IR_enable mid-request
    IR_enable = 1'b1;
    tick();
    IR_enable = 1'b0;
    cnt = 0; addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      if (imem_req && fetch_busy) cnt++;
      if (imem_addr !== 16'h0000) addr_ok = 0;
      if (k == 2) chk("b_pc_mid_req", pc, 32'h1);
      PC_enable = (k == 1);
      IR_enable = (k == 1);
      if (k == 3) begin imem_ack = 1'b1; imem_rdata = 32'h0123_4567; end
      tick();
    end
    PC_enable = 1'b0; IR_enable = 1'b0; imem_ack = 1'b0;
    chk("b_req_cycles", cnt, 32'd4);
    chk("b_addr_held", {31'h0, addr_ok}, 32'h1);
    chk("b_done", {imem_req, instr_valid}, 32'h1);
    chk("b_ir", {opcode, rd, rs1, rs2[4], imm}, 32'h0123_4567);
    tick();
    chk("b_no_refetch", imem_req, 32'h0);

    // Simultaneous IR_enable and PC_enable: request uses pre-update pc
    IR_enable = 1'b1; PC_enable = 1'b1;
    tick();
    IR_enable = 1'b0; PC_enable = 1'b0;
    chk("c_addr_pre", imem_addr, 32'h1);
    chk("c_pc_post", pc, 32'h2);
    imem_ack = 1'b1; imem_rdata = 32'h0;
    tick();
    imem_ack = 1'b0;

    // Table-driven next-PC vectors
    foreach (vecs[i]) begin
      set_pc(vecs[i].start_pc);
      chk($sformatf("v%0d_start_pc", i), pc, {16'h0, vecs[i].start_pc});
      fetch(vecs[i].word, i % 3);
      w = vecs[i].word;
      chk($sformatf("v%0d_fields", i), {instr_valid, opcode, imm}, {10'h0, 1'b1, w[31:27], w[15:0]});
      pc_step(vecs[i].j, vecs[i].b, vecs[i].c);
      chk($sformatf("v%0d_pc", i), pc, {16'h0, vecs[i].exp_pc});
    end

    // Reset asserted mid-request
    IR_enable = 1'b1;
    tick();
    IR_enable = 1'b0;
    chk("r_req_before", imem_req, 32'h1);
    reset = 1'b1;
    #1;
    chk("r_req_async_drop", {imem_req, fetch_busy}, 32'h0);
    chk("r_pc_reset", pc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    imem_ack = 1'b0;
    chk("r_late_ack_ignored", {instr_valid, imem_req, opcode}, 32'h0);

    // Ack never arrives
    fetch(32'h4880_0005, 0);
    IR_enable = 1'b1;
    tick();
    IR_enable = 1'b0;
    cnt = 0;
    while (imem_req && cnt < 40) begin
      cnt++;
      tick();
    end
`ifdef IFU_ACK_TIMEOUT_EN
    chk("wd_req_cycles", cnt, TIMEOUT);
    chk("wd_abort", {instr_valid, fetch_err, opcode}, {25'h0, 2'b11, 5'h00});
    fetch(32'h4880_0005, 1);
    chk("wd_err_sticky", {instr_valid, fetch_err}, 32'h3);
    do_reset();
    chk("wd_err_cleared", fetch_err, 32'h0);
`else
    chk("nowd_wait", cnt, 32'd40);
    chk("nowd_state", {imem_req, instr_valid, fetch_err}, 32'h4);
    do_reset();
`endif

    // Randomized run against the reference model
    m_pc = 0; m_ir = 32'h0; m_valid = 0; m_busy = 0; m_err = 0; m_addr = 16'h0; m_wd = 0;
    for (int c = 0; c < 400; c++) begin
      IR_enable   = ($urandom_range(0, 9) < 3);
      PC_enable   = ($urandom_range(0, 9) < 3);
      jump        = ($urandom_range(0, 5) == 0);
      branch      = ($urandom_range(0, 2) == 0);
      branch_cond = $urandom_range(0, 1) == 1;
      imem_ack    = ($urandom_range(0, 2) == 0);
      imem_rdata  = $urandom;
      model_step();
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_ir", {opcode, rd, rs1, rs2[4], imm}, m_ir);
      chk("rnd_flags", {imem_req, fetch_busy, instr_valid, fetch_err},
          {28'h0, m_busy, m_busy, m_valid, m_err});
      if (m_busy) chk("rnd_addr", imem_addr, {16'h0, m_addr});
    end
    IR_enable = 0; PC_enable = 0; jump = 0; branch = 0; branch_cond = 0; imem_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Owns the program counter and instruction register of the multi-cycle RISC core and sits directly upstream of the multi-cycle control unit. On each fetch it issues a handshaked read to instruction memory and latches the returned word into the IR. It then presents the opcode and operand fields to the control unit and datapath, and updates the PC when the control unit asserts `PC_enable`.

## Interface
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: cycles without `imem_ack` before a fetch aborts (used only when the watchdog is compiled in).

- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `IR_enable`  in  1: fetch request from control unit (FETCH state).
- `PC_enable`  in  1: PC update strobe from control unit.
- `branch`  in  1: current instruction is BEQ/BNE.
- `jump`  in  1: current instruction is JUMP.
- `branch_cond`  in  1: datapath comparison result, already qualified for BEQ/BNE.
- `imem_req`  out  1: memory read request.
- `imem_addr`  out  ADDR_W: word address of the request.
- `imem_rdata`  in  32: instruction word.
- `imem_ack`  in  1: `imem_rdata` valid this cycle.
- `opcode`  out  5: IR[31:27].
- `rd`, `rs1`, `rs2`  out  5 each: IR[26:22], IR[21:17], IR[16:12].
- `imm`  out  16: IR[15:0], raw.
- `pc`  out  ADDR_W: current PC.
- `instr_valid`  out  1: IR holds a completed fetch.
- `fetch_busy`  out  1: fetch in flight. The control unit holds FETCH while this is high.
- `fetch_err`  out  1: sticky timeout flag (watchdog builds only; tied 0 otherwise).

## Operation
- FSM states:
  - IDLE: no valid IR.
  - REQ: waiting for `imem_ack`.
  - HOLD: IR valid.
- IDLE/HOLD + `IR_enable`: go to REQ.
  - Capture `pc` into `req_addr`.
  - Clear `instr_valid`.
- REQ + `imem_ack`: load IR from `imem_rdata`, set `instr_valid`, go to HOLD.
- `IR_enable` while in REQ is ignored.
- `imem_req` = (state == REQ), registered. `imem_addr` = `req_addr`, stable for the whole request.
- `fetch_busy` = (state == REQ).
- PC update on a `PC_enable` edge, by priority:
  - `jump`: pc ← IR[ADDR_W-1:0].
  - `branch` & `branch_cond`: pc ← pc + 1 + sext(imm).
  - Otherwise: pc ← pc + 1.
- All PC arithmetic is modulo 2^ADDR_W. 0xFFFF + 1 wraps to 0x0000 at ADDR_W=16.
- `PC_enable` is honoured in every state. During REQ it changes `pc` but not `imem_addr`.
- Simultaneous `IR_enable` and `PC_enable` in the same cycle: `req_addr` captures the pre-update `pc`.

## Timing
- Reset values:
  - pc = RESET_PC
  - IR = 0, so opcode/rd/rs1/rs2/imm = 0
  - `imem_req` = 0, `instr_valid` = 0, `fetch_busy` = 0, `fetch_err` = 0
  - state = IDLE
- `IR_enable` high in cycle N: `imem_req` and `fetch_busy` are high from cycle N+1.
- `imem_ack` sampled in cycle M ≥ N+1: IR, `instr_valid` and HOLD all take effect from M+1. `imem_req` drops in M+1.
- Minimum fetch latency is 2 cycles from `IR_enable` to `instr_valid`.
- `imem_ack` while not in REQ is ignored.
- PC update is visible one cycle after the `PC_enable` edge.
- Reset asserted mid-request: `imem_req` drops asynchronously. Any later ack is ignored.

## Configuration
- `IFU_ACK_TIMEOUT_EN` defined: a watchdog counter clears on entry to REQ and increments each REQ cycle without ack. On reaching TIMEOUT:
  - Abort the request and go to HOLD.
  - Load IR with the NOP encoding and set `instr_valid`.
  - Set `fetch_err`, which stays set until reset.
- `IFU_ACK_TIMEOUT_EN` undefined: REQ waits indefinitely, and `fetch_err` is constant 0.

## Structure
- Shared package `isa_pkg` holds:
  - Opcode constants: R-type < 5'd7, BEQ 5'b00111, BNE 5'b01000, LOAD 5'b01001, STORE 5'b01010, JUMP 5'b01011.
  - IR field bit positions.
  - NOP encoding: 32'h0.
  - FSM state encodings.
- One sub-module, `ifu_next_pc`: combinational next-PC select and adder.

## Test plan
- Reset, then `IR_enable` with ack in the same cycle as req, `imem_rdata`=32'h4880_0005 → `imem_addr`=0, `instr_valid` 2 cycles after `IR_enable`, opcode=5'b01001, imm=0x0005.
- Ack delayed 3 cycles → `imem_req`/`fetch_busy` high for 4 cycles, `imem_addr` held at 0x0000. `PC_enable` mid-request → pc=1, `imem_addr` unchanged.
- pc=0x0010, BEQ with imm=0xFFFC, `branch_cond`=1, then `PC_enable` → pc=0x000D. Same with `branch_cond`=0 → pc=0x0011.
- JUMP with IR[15:0]=0x0200 and `branch` also high, then `PC_enable` → pc=0x0200 (jump wins).
- pc=0xFFFF, then `PC_enable` → pc=0x0000. Reset asserted during REQ → `imem_req`=0 immediately, pc=RESET_PC, later ack ignored.
- With `IFU_ACK_TIMEOUT_EN` and TIMEOUT=15, no ack → abort after 15 REQ cycles, opcode=0, `instr_valid`=1, `fetch_err`=1 until reset.
